mac_cfg_loader: RTL and testbench

Upstream configuration front-end for `mac_cluster`. It accepts the cluster's packed configuration as a stream of fixed-width words over a valid/ready handshake. Words are assembled in a shadow register. After a well-formed frame, the loader updates the `cfg` bus and pulses `cset` for one cycle so the cluster latches the new mode and initial accumulator values. Malformed frames are discarded without disturbing the active configuration.

---
 rtl/mac_cfg_loader.sv | 109 ++++++++++
 tb/tb_mac_cfg_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_cfg_loader.sv
// Configuration front-end for mac_cluster: assembles a framed word stream into a
// shadow register and applies it to cfg with a one-cycle cset strobe.
module mac_cfg_loader #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int WORD_WIDTH     = 32,
  localparam int CFG_WIDTH     = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH,
  localparam int NUM_WORDS     = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [CFG_WIDTH-1:0]  cfg,
  output logic                  cset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam logic [WCW-1:0] LAST_IDX = WCW'(NUM_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;

  // Operand width only documents the cluster; reject configurations that cannot fit.
  if (MAC_MIN_WIDTH > MAC_ACC_WIDTH) begin : g_bad_widths
    $error("mac_cfg_loader: MAC_MIN_WIDTH exceeds MAC_ACC_WIDTH");
  end

  logic [1:0]           state;
  logic [WCW-1:0]       wcnt;
  logic [WCW-1:0]       wr_idx;
  logic [CFG_WIDTH-1:0] shadow;
  logic [CFG_WIDTH-1:0] shadow_nxt;
  logic                 xfer;

  assign in_ready = reset & (state != S_APPLY);
  assign xfer     = in_valid & in_ready;
  assign busy     = (state != S_IDLE);
  assign cset     = (state == S_APPLY);

  // Shadow with the incoming word merged in; bits past CFG_WIDTH are simply never stored.
  always_comb begin
    wr_idx     = (state == S_IDLE) ? '0 : wcnt;
    shadow_nxt = shadow;
    for (int b = 0; b < CFG_WIDTH; b++) begin
      if (wr_idx == WCW'(b / WORD_WIDTH)) shadow_nxt[b] = in_data[b % WORD_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      wcnt   <= '0;
      shadow <= '0;
      cfg    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            shadow <= shadow_nxt;
            wcnt   <= WCW'(1);
            if (in_last && (NUM_WORDS > 1)) begin
              err  <= 1'b1;
              wcnt <= '0;
            end else if (in_last) begin
              cfg   <= shadow_nxt;
              state <= S_APPLY;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            shadow <= shadow_nxt;
            if (in_last && (wcnt == LAST_IDX)) begin
              cfg   <= shadow_nxt;
              wcnt  <= wcnt + 1'b1;
              state <= S_APPLY;
            end else if (in_last || (wcnt >= LAST_IDX)) begin
              err   <= 1'b1;
              wcnt  <= '0;
              state <= S_IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        S_APPLY: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Randomized self-checking bench for mac_cfg_loader against a queue-based frame model.
module tb_mac_cfg_loader;

  localparam int CW   = 4;
  localparam int AW   = 32;
  localparam int WW   = 32;
  localparam int CFGW = 4 * AW + CW;
  localparam int NW   = (CFGW + WW - 1) / WW;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [WW-1:0]   in_data;
  logic            in_last;
  logic [CFGW-1:0] cfg;
  logic            cset;
  logic            busy;
  logic            done;
  logic            err;

  mac_cfg_loader #(
    .MAC_CONF_WIDTH(CW),
    .MAC_MIN_WIDTH (8),
    .MAC_ACC_WIDTH (AW),
    .WORD_WIDTH    (WW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_last (in_last),
    .cfg     (cfg),
    .cset    (cset),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cset_cycles[$];

  // Reference model: the words of the frame in flight plus the pulses due this cycle.
  logic [WW-1:0]   m_frame[$];
  logic [CFGW-1:0] m_cfg  = '0;
  logic            m_cset = 1'b0;
  logic            m_done = 1'b0;
  logic            m_err  = 1'b0;
  logic [WW-1:0]   frame_buf[NW];

  localparam logic [CFGW-1:0] NOMINAL = {32'd4, 32'd3, 32'd2, 32'd1, 4'd5};

  task automatic checkOutput(input string tag, input logic [CFGW-1:0] got, input logic [CFGW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [CFGW-1:0] packFrame();
    logic [NW*WW-1:0] v = '0;
    for (int i = 0; i < NW; i++) v = v | ((NW*WW)'(m_frame[i]) << (WW * i));
    return v[CFGW-1:0];
  endfunction

  task automatic checkAll();
    checkOutput("in_ready", CFGW'(in_ready), CFGW'(reset && !m_cset));
    checkOutput("cset",     CFGW'(cset),     CFGW'(m_cset));
    checkOutput("done",     CFGW'(done),     CFGW'(m_done));
    checkOutput("err",      CFGW'(err),      CFGW'(m_err));
    checkOutput("busy",     CFGW'(busy),     CFGW'((m_frame.size() != 0) || m_cset));
    checkOutput("cfg",      cfg,             m_cfg);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at the falling edge.
  task automatic applyStimulus(input logic v, input logic [WW-1:0] d, input logic l, input logic r);
    logic xfer;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    reset    = r;
    xfer     = v && r && !m_cset;
    @(posedge clk);
    if (!r) begin
      m_frame.delete();
      m_cfg  = '0;
      m_cset = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_done = m_cset;
      m_cset = 1'b0;
      m_err  = 1'b0;
      if (xfer) begin
        m_frame.push_back(d);
        if (l) begin
          if (m_frame.size() == NW) begin
            m_cfg  = packFrame();
            m_cset = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_frame.delete();
        end else if (m_frame.size() == NW) begin
          m_err = 1'b1;
          m_frame.delete();
        end
      end
    end
    @(negedge clk);
    cyc++;
    if (cset) cset_cycles.push_back(cyc);
    checkAll();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, $urandom, 1'($urandom), 1'b1);
  endtask

  task automatic sendWord(input logic [WW-1:0] w, input logic last, input int stall);
    idle(stall);
    while (m_cset) idle(1);
    applyStimulus(1'b1, w, last, 1'b1);
  endtask

  task automatic sendFrame(input int n, input int last_idx, input int stall, input bit rand_stall);
    for (int i = 0; i < n; i++) begin
      sendWord(frame_buf[i], (i == last_idx), (i == 0) ? 0 : (rand_stall ? $urandom_range(0, stall) : stall));
    end
  endtask

  task automatic loadNominal();
    frame_buf[0] = 32'h15;
    frame_buf[1] = 32'h20;
    frame_buf[2] = 32'h30;
    frame_buf[3] = 32'h40;
    frame_buf[4] = 32'h0;
  endtask

  task automatic loadRandom();
    for (int i = 0; i < NW; i++) frame_buf[i] = $urandom;
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    reset    = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, '1, 1'b1, 1'b0);
    idle(2);

    loadNominal();
    sendFrame(NW, NW - 1, 0, 1'b0);
    checkOutput("nominal_cfg", cfg, NOMINAL);
    checkOutput("nominal_cset", CFGW'(cset), CFGW'(1));
    idle(2);

    loadRandom();
    sendFrame(3, 2, 0, 1'b0);
    idle(2);
    checkOutput("early_last_keeps_cfg", cfg, NOMINAL);
    loadRandom();
    sendFrame(NW, NW - 1, 0, 1'b0);
    idle(2);

    loadRandom();
    sendFrame(NW, -1, 0, 1'b0);
    checkOutput("missing_last_keeps_cfg", cfg, m_cfg);
    loadRandom();
    sendFrame(NW, NW - 1, 0, 1'b0);
    idle(2);

    loadNominal();
    sendFrame(NW, NW - 1, 2, 1'b0);
    checkOutput("stall_cfg", cfg, NOMINAL);
    idle(2);

    loadRandom();
    sendFrame(3, -1, 0, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
    checkOutput("reset_cfg", cfg, '0);
    checkOutput("reset_busy", CFGW'(busy), '0);
    loadRandom();
    sendFrame(NW, NW - 1, 0, 1'b0);
    idle(2);

    cset_cycles.delete();
    for (int i = 0; i < NW; i++) frame_buf[i] = '1;
    sendFrame(NW, NW - 1, 0, 1'b0);
    checkOutput("all_ones_cfg", cfg, '1);
    loadNominal();
    sendFrame(NW, NW - 1, 0, 1'b0);
    checkOutput("b2b_second_cfg", cfg, NOMINAL);
    idle(2);
    checkOutput("b2b_cset_count", CFGW'(cset_cycles.size()), CFGW'(2));
    if (cset_cycles.size() == 2)
      checkOutput("b2b_spacing", CFGW'(cset_cycles[1] - cset_cycles[0]), CFGW'(NW + 1));

    for (int f = 0; f < 60; f++) begin
      int kind;
      int n;
      kind = $urandom_range(0, 9);
      loadRandom();
      if (kind <= 5) begin
        sendFrame(NW, NW - 1, 2, 1'b1);
      end else if (kind == 6) begin
        n = $urandom_range(1, NW - 1);
        sendFrame(n, n - 1, 2, 1'b1);
      end else if (kind == 7) begin
        sendFrame(NW, -1, 2, 1'b1);
      end else begin
        n = $urandom_range(0, NW);
        sendFrame(n, (n == NW) ? NW - 1 : -1, 1, 1'b1);
        applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'b0);
      end
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no completion expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
